// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer for a word-only single-port data memory.
// Byte/half stores are read-modify-write; loads are sign/zero extended.
module dmem_lsu_ctrl #(
    parameter int WIDTH = 32,
    parameter int AW    = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             core_req_i,
    input  logic             core_we_i,
    input  logic [2:0]       core_size_i,
    input  logic [AW-1:0]    core_addr_i,
    input  logic [WIDTH-1:0] core_wd_i,
    output logic [WIDTH-1:0] core_rd_o,
    output logic             core_stall_o,
    output logic             misalign_o,
    output logic [AW-1:0]    mem_a_o,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_wd_o,
    input  logic [WIDTH-1:0] mem_rd_i
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_DONE,
        RMW_WRITE
    } state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    addr_q;
    logic [2:0]       size_q;
    logic [15:0]      wd_q;
    logic [WIDTH-1:0] rdata_q;

    logic             illegal;
    logic             capture;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [WIDTH-1:0] ext_rd;
    logic [WIDTH-1:0] merged;

    logic [WIDTH-1:0] rd_c;
    logic             stall_c;
    logic             mis_c;
    logic [AW-1:0]    a_c;
    logic             we_c;
    logic [WIDTH-1:0] wd_c;

    always_comb begin
        case (core_size_i)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = core_addr_i[0];
            3'b010:  illegal = |core_addr_i[1:0];
            3'b100:  illegal = core_we_i;
            3'b101:  illegal = core_we_i | core_addr_i[0];
            default: illegal = 1'b1;
        endcase
    end

    assign lane_b = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h = rdata_q[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        case (size_q)
            3'b000:  ext_rd = {{(WIDTH-8){lane_b[7]}}, lane_b};
            3'b100:  ext_rd = {{(WIDTH-8){1'b0}}, lane_b};
            3'b001:  ext_rd = {{(WIDTH-16){lane_h[15]}}, lane_h};
            3'b101:  ext_rd = {{(WIDTH-16){1'b0}}, lane_h};
            default: ext_rd = rdata_q;
        endcase
    end

    always_comb begin
        merged = rdata_q;
        if (size_q[0])
            merged[{addr_q[1], 4'b0000} +: 16] = wd_q;
        else
            merged[{addr_q[1:0], 3'b000} +: 8] = wd_q[7:0];
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        rd_c      = '0;
        stall_c   = 1'b0;
        mis_c     = 1'b0;
        a_c       = '0;
        we_c      = 1'b0;
        wd_c      = '0;
        case (state)
            IDLE: begin
                if (core_req_i) begin
                    if (illegal) begin
                        mis_c = 1'b1;
                    end else if (core_we_i && core_size_i == 3'b010) begin
                        a_c  = {core_addr_i[AW-1:2], 2'b00};
                        we_c = 1'b1;
                        wd_c = core_wd_i;
                    end else begin
                        // Sub-word store reads the word first, like a load
                        a_c       = {core_addr_i[AW-1:2], 2'b00};
                        stall_c   = 1'b1;
                        capture   = 1'b1;
                        state_nxt = core_we_i ? RMW_WRITE : LOAD_DONE;
                    end
                end
            end
            LOAD_DONE: begin
                rd_c      = ext_rd;
                state_nxt = IDLE;
            end
            RMW_WRITE: begin
                a_c       = {addr_q[AW-1:2], 2'b00};
                we_c      = 1'b1;
                wd_c      = merged;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted, aborting any write
    assign core_rd_o    = RST_N ? rd_c    : '0;
    assign core_stall_o = RST_N & stall_c;
    assign misalign_o   = RST_N & mis_c;
    assign mem_a_o      = RST_N ? a_c     : '0;
    assign mem_we_o     = RST_N & we_c;
    assign mem_wd_o     = RST_N ? wd_c    : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                addr_q  <= core_addr_i;
                size_q  <= core_size_i;
                wd_q    <= core_wd_i[15:0];
                rdata_q <= mem_rd_i;
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl with a 16-word behavioural data memory.
module tb_dmem_lsu_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        misalign_o;
    logic [31:0] mem_a_o;
    logic        mem_we_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;

    logic [31:0] mem [0:15];
    int          n_wr;
    int          n_vec;
    int          n_cmp;
    int          n_fail;

    dmem_lsu_ctrl #(.WIDTH(32), .AW(32)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .misalign_o   (misalign_o),
        .mem_a_o      (mem_a_o),
        .mem_we_o     (mem_we_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign mem_rd_i = mem[mem_a_o[5:2]];

    always @(posedge CLK) begin
        if (mem_we_o) begin
            mem[mem_a_o[5:2]] <= mem_wd_o;
            n_wr <= n_wr + 1;
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_stall;
        logic        exp_mis;
        int          exp_wr;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vt [22];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_txn(input logic we, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int stalls, output logic mis,
                          output logic [31:0] rd);
        stalls = 0;
        @(negedge CLK);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        #1;
        while (core_stall_o && stalls < 8) begin
            stalls++;
            @(negedge CLK);
            #1;
        end
        mis = misalign_o;
        rd  = core_rd_o;
        @(negedge CLK);
        core_req_i = 1'b0;
        core_we_i  = 1'b0;
    endtask

    int          st;
    logic        mis;
    logic [31:0] rd;
    int          wr0;

    initial begin
        n_wr = 0; n_vec = 0; n_cmp = 0; n_fail = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;

        //          we    size    addr   wd            exp_rd        st mis wr exp_word
        vt[0]  = '{1'b1, 3'b010, 32'h0, 32'h11223344, 32'h0,        0, 0, 1, 32'h11223344};
        vt[1]  = '{1'b0, 3'b000, 32'h3, 32'h0,        32'h00000011, 1, 0, 0, 32'h11223344};
        vt[2]  = '{1'b0, 3'b100, 32'h0, 32'h0,        32'h00000044, 1, 0, 0, 32'h11223344};
        vt[3]  = '{1'b1, 3'b010, 32'h4, 32'h80FF7F01, 32'h0,        0, 0, 1, 32'h80FF7F01};
        vt[4]  = '{1'b0, 3'b001, 32'h6, 32'h0,        32'hFFFF80FF, 1, 0, 0, 32'h80FF7F01};
        vt[5]  = '{1'b0, 3'b101, 32'h6, 32'h0,        32'h000080FF, 1, 0, 0, 32'h80FF7F01};
        vt[6]  = '{1'b0, 3'b000, 32'h5, 32'h0,        32'h0000007F, 1, 0, 0, 32'h80FF7F01};
        vt[7]  = '{1'b0, 3'b000, 32'h7, 32'h0,        32'hFFFFFF80, 1, 0, 0, 32'h80FF7F01};
        vt[8]  = '{1'b0, 3'b101, 32'h4, 32'h0,        32'h00007F01, 1, 0, 0, 32'h80FF7F01};
        vt[9]  = '{1'b1, 3'b010, 32'h8, 32'h11223344, 32'h0,        0, 0, 1, 32'h11223344};
        vt[10] = '{1'b1, 3'b000, 32'h9, 32'h000000AA, 32'h0,        1, 0, 1, 32'h1122AA44};
        vt[11] = '{1'b0, 3'b010, 32'h8, 32'h0,        32'h1122AA44, 1, 0, 0, 32'h1122AA44};
        vt[12] = '{1'b1, 3'b010, 32'hC, 32'hDEADBEEF, 32'h0,        0, 0, 1, 32'hDEADBEEF};
        vt[13] = '{1'b0, 3'b010, 32'hC, 32'h0,        32'hDEADBEEF, 1, 0, 0, 32'hDEADBEEF};
        vt[14] = '{1'b1, 3'b001, 32'hE, 32'hFFFF1234, 32'h0,        1, 0, 1, 32'h1234BEEF};
        vt[15] = '{1'b0, 3'b010, 32'hC, 32'h0,        32'h1234BEEF, 1, 0, 0, 32'h1234BEEF};
        vt[16] = '{1'b0, 3'b010, 32'h2, 32'h0,        32'h0,        0, 1, 0, 32'h11223344};
        vt[17] = '{1'b1, 3'b001, 32'h1, 32'h5555,     32'h0,        0, 1, 0, 32'h11223344};
        vt[18] = '{1'b0, 3'b011, 32'h0, 32'h0,        32'h0,        0, 1, 0, 32'h11223344};
        vt[19] = '{1'b1, 3'b100, 32'h0, 32'h66,       32'h0,        0, 1, 0, 32'h11223344};
        vt[20] = '{1'b1, 3'b000, 32'h3, 32'h000000C3, 32'h0,        1, 0, 1, 32'hC3223344};
        vt[21] = '{1'b0, 3'b000, 32'h3, 32'h0,        32'hFFFFFFC3, 1, 0, 0, 32'hC3223344};

        RST_N       = 1'b0;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'b010;
        core_addr_i = 32'h4;
        core_wd_i   = 32'h0;
        #1;
        chk("rst_stall", {31'b0, core_stall_o}, 32'h0);
        chk("rst_mem_a", mem_a_o, 32'h0);
        chk("rst_we", {31'b0, mem_we_o}, 32'h0);
        core_size_i = 3'b111;
        #1;
        chk("rst_mis", {31'b0, misalign_o}, 32'h0);
        core_req_i = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("idle_rd", core_rd_o, 32'h0);
        chk("idle_a", mem_a_o, 32'h0);
        chk("idle_we", {31'b0, mem_we_o}, 32'h0);

        for (int i = 0; i < 22; i++) begin
            wr0 = n_wr;
            do_txn(vt[i].we, vt[i].size, vt[i].addr, vt[i].wd, st, mis, rd);
            n_vec++;
            chk($sformatf("v%0d_stall", i), st, vt[i].exp_stall);
            chk($sformatf("v%0d_mis", i), {31'b0, mis}, {31'b0, vt[i].exp_mis});
            chk($sformatf("v%0d_rd", i), rd, vt[i].exp_rd);
            chk($sformatf("v%0d_nwr", i), n_wr - wr0, vt[i].exp_wr);
            chk($sformatf("v%0d_mem", i), mem[vt[i].addr[5:2]], vt[i].exp_word);
        end

        // SB write address/data are visible in RMW_WRITE; reset aborts it
        mem[0] = 32'h11223344;
        wr0 = n_wr;
        @(negedge CLK);
        core_req_i  = 1'b1;
        core_we_i   = 1'b1;
        core_size_i = 3'b000;
        core_addr_i = 32'h1;
        core_wd_i   = 32'h000000FF;
        #1;
        chk("rmw_stall", {31'b0, core_stall_o}, 32'h1);
        chk("rmw_nowe", {31'b0, mem_we_o}, 32'h0);
        @(posedge CLK);
        #1;
        chk("rmw_we", {31'b0, mem_we_o}, 32'h1);
        chk("rmw_a", mem_a_o, 32'h0);
        chk("rmw_wd", mem_wd_o, 32'h1122FF44);
        RST_N = 1'b0;
        #1;
        chk("abort_we", {31'b0, mem_we_o}, 32'h0);
        core_req_i = 1'b0;
        core_we_i  = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        #1;
        chk("abort_mem", mem[0], 32'h11223344);
        chk("abort_nwr", n_wr - wr0, 32'h0);
        chk("abort_idle", {31'b0, core_stall_o}, 32'h0);
        do_txn(1'b0, 3'b010, 32'h0, 32'h0, st, mis, rd);
        n_vec++;
        chk("post_abort_stall", st, 32'h1);
        chk("post_abort_rd", rd, 32'h11223344);

        // Reset while the load result is presented clears it
        @(negedge CLK);
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'b000;
        core_addr_i = 32'h3;
        @(negedge CLK);
        #1;
        chk("ld_done_rd", core_rd_o, 32'h00000011);
        RST_N = 1'b0;
        #1;
        chk("ld_rst_rd", core_rd_o, 32'h0);
        core_req_i = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        #1;
        chk("ld_rst_idle", core_rd_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
